// File: rtl/types_pkg.sv
// rtl/types_pkg.sv - shared FSM states, func3 codes, store entry and lane helpers
package types_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LD_REQ   = 2'd1,
        LD_RESP  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  func3;
    } st_entry_t;

    // Pick the addressed byte/half out of a read word and extend it.
    function automatic logic [31:0] load_extract(input logic [2:0] func3,
                                                 input logic [1:0] a,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{a, 3'b000} +: 8];
        h = a[1] ? word[31:16] : word[15:0];
        case (func3)
            F3_LB:   r = {{24{b[7]}}, b};
            F3_LH:   r = {{16{h[15]}}, h};
            F3_LW:   r = word;
            F3_LBU:  r = {24'h0, b};
            F3_LHU:  r = {16'h0, h};
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] store_we(input logic [2:0] func3,
                                            input logic [1:0] a);
        logic [3:0] r;
        case (func3)
            F3_SB:   r = 4'b0001 << a;
            F3_SH:   r = a[1] ? 4'b1100 : 4'b0011;
            F3_SW:   r = 4'b1111;
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    // Replicate narrow data across all lanes; byte enables select the lane.
    function automatic logic [31:0] store_wdata(input logic [2:0] func3,
                                                input logic [31:0] d);
        logic [31:0] r;
        case (func3)
            F3_SB:   r = {4{d[7:0]}};
            F3_SH:   r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - retired-store FIFO with word-address hit detection
// Ports: clk, reset (sync active-low), push/push_entry, pop, head,
//        full, empty, match_word (addr[31:2] to probe), hit (any live entry matches).
module store_buffer
    import types_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  st_entry_t   push_entry,
    input  logic        pop,
    output st_entry_t   head,
    output logic        full,
    output logic        empty,
    input  logic [29:0] match_word,
    output logic        hit
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    st_entry_t         mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count_q;
    logic              push_ok;
    logic              pop_ok;
    logic [PW-1:0]     idx;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_entry;
    end

    // Only the count entries starting at rd_ptr are live.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if ((CW'(i) < count_q) && (mem[idx].addr[31:2] == match_word))
                hit = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_scheduler.sv
// rtl/mem_port_scheduler.sv - arbitrates loads and retired stores onto one BRAM port
// Ports: clk, reset (sync active-low); load req ld_*; store req st_*;
//        flush window mispredict/mispredict_tag/curr_rob_tag; BRAM mem_*;
//        load completion ld_done/ld_data/ld_rob_out.
module mem_port_scheduler
    import types_pkg::*;
#(
    parameter int SB_DEPTH = 4,
    parameter int ROB_W    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [31:0]      ld_addr,
    input  logic [2:0]       ld_func3,
    input  logic [ROB_W-1:0] ld_rob,
    input  logic             st_valid,
    output logic             st_ready,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
    input  logic [2:0]       st_func3,
    input  logic             mispredict,
    input  logic [ROB_W-1:0] mispredict_tag,
    input  logic [ROB_W-1:0] curr_rob_tag,
    output logic             mem_en,
    output logic [3:0]       mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    output logic             ld_done,
    output logic [31:0]      ld_data,
    output logic [ROB_W-1:0] ld_rob_out
);

    state_t           state;
    state_t           next_state;
    logic [31:0]      ld_addr_q;
    logic [2:0]       ld_func3_q;
    logic [ROB_W-1:0] ld_rob_q;

    logic             sb_full;
    logic             sb_empty;
    logic             sb_hit;
    logic             sb_push;
    logic             sb_pop;
    st_entry_t        sb_head;
    logic             ld_fire;
    logic             kill_new;
    logic             kill_flight;

    // Younger means strictly after the mispredicted branch and before the
    // current allocation point, measured modulo the tag space.
    function automatic logic is_younger(input logic [ROB_W-1:0] tag,
                                        input logic [ROB_W-1:0] mtag,
                                        input logic [ROB_W-1:0] ctag);
        logic [ROB_W-1:0] d;
        logic [ROB_W-1:0] w;
        d = tag - mtag;
        w = ctag - mtag;
        return (d != '0) && (d < w);
    endfunction

    assign kill_new    = mispredict && is_younger(ld_rob, mispredict_tag, curr_rob_tag);
    assign kill_flight = mispredict && is_younger(ld_rob_q, mispredict_tag, curr_rob_tag);

    assign st_ready = !sb_full;
    assign sb_push  = reset && st_valid && st_ready;
    assign sb_pop   = reset && (state == ST_WRITE);
    // A load to a word with a pending store waits until that store drains.
    assign ld_ready = reset && (state == IDLE) && !sb_full && !sb_hit && !kill_new;
    assign ld_fire  = ld_valid && ld_ready;

    store_buffer #(.DEPTH(SB_DEPTH)) u_sb (
        .clk        (clk),
        .reset      (reset),
        .push       (sb_push),
        .push_entry ('{addr: st_addr, data: st_data, func3: st_func3}),
        .pop        (sb_pop),
        .head       (sb_head),
        .full       (sb_full),
        .empty      (sb_empty),
        .match_word (ld_addr[31:2]),
        .hit        (sb_hit)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            ld_addr_q  <= '0;
            ld_func3_q <= '0;
            ld_rob_q   <= '0;
        end else begin
            state <= next_state;
            if (ld_fire) begin
                ld_addr_q  <= ld_addr;
                ld_func3_q <= ld_func3;
                ld_rob_q   <= ld_rob;
            end
        end
    end

    always_comb begin
        next_state = state;
        mem_en     = 1'b0;
        mem_we     = 4'b0000;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
        ld_done    = 1'b0;
        ld_data    = 32'h0;
        ld_rob_out = '0;
        case (state)
            IDLE: begin
                if (sb_full)        next_state = ST_WRITE;
                else if (ld_fire)   next_state = LD_REQ;
                else if (!sb_empty) next_state = ST_WRITE;
            end
            LD_REQ: begin
                mem_en     = 1'b1;
                mem_addr   = {ld_addr_q[31:2], 2'b00};
                next_state = kill_flight ? IDLE : LD_RESP;
            end
            LD_RESP: begin
                next_state = IDLE;
                // Gated by reset so a load caught by reset never completes.
                if (reset && !kill_flight) begin
                    ld_done    = 1'b1;
                    ld_data    = load_extract(ld_func3_q, ld_addr_q[1:0], mem_rdata);
                    ld_rob_out = ld_rob_q;
                end
            end
            ST_WRITE: begin
                mem_en     = 1'b1;
                mem_we     = store_we(sb_head.func3, sb_head.addr[1:0]);
                mem_addr   = {sb_head.addr[31:2], 2'b00};
                mem_wdata  = store_wdata(sb_head.func3, sb_head.data);
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule
